// File: rtl/overlap_1010.sv
// Overlapping 1-0-1-0 serial pattern detector.
// Moore variant by default; define MEALY_MACHINE for the Mealy variant.
module overlap_1010 (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic out
);

`ifdef MEALY_MACHINE

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= in ? S1   : IDLE;
        S1:      state <= in ? S1   : S10;
        S10:     state <= in ? S101 : IDLE;
        // Final 0 of a match: the trailing "10" seeds the next search.
        S101:    state <= in ? S1   : S10;
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational flag; held low while reset is asserted.
  assign out = (state == S101) && !in && !rstn;

`else

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1010 = 3'd4
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= in ? S1   : IDLE;
        S1:      state <= in ? S1   : S10;
        S10:     state <= in ? S101 : IDLE;
        S101:    state <= in ? S1   : S1010;
        // After a match, "10" already seen: a 1 makes "101".
        S1010:   state <= in ? S101 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded straight from the state register, so glitch-free.
  assign out = (state == S1010);

`endif

endmodule

// File: tb/tb_overlap_1010.sv
// Directed and random-soak bench for overlap_1010 (either FSM variant).
module tb_overlap_1010;

  logic clk;
  logic rstn;
  logic in;
  logic out;

  int tests;
  int fails;
  int obs_cnt;
  int ref_cnt;
  logic [3:0] hist;

  overlap_1010 dut (
    .clk  (clk),
    .rstn (rstn),
    .in   (in),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Mealy out is sampled before the edge that consumes the bit, Moore just after it.
  task automatic drive_bit(input string tag, input logic b, input logic exp);
    @(negedge clk);
    rstn = 1'b0;
    in   = b;
    #2;
`ifdef MEALY_MACHINE
    check(tag, 32'(out), 32'(exp));
    obs_cnt += int'(out);
`endif
    @(posedge clk);
    #1;
`ifndef MEALY_MACHINE
    check(tag, 32'(out), 32'(exp));
    obs_cnt += int'(out);
`endif
  endtask

  task automatic do_reset(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rstn = 1'b1;
      in   = 1'(i);
      #2;
`ifdef MEALY_MACHINE
      check(tag, 32'(out), 32'd0);
`endif
      @(posedge clk);
      #1;
`ifndef MEALY_MACHINE
      check(tag, 32'(out), 32'd0);
`endif
    end
    hist = 4'b0000;
  endtask

  // bits and exp are listed first-in-time at bit n-1.
  task automatic drive_seq(input string tag, input int n, input logic [31:0] bits,
                           input logic [31:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(tag, bits[i], exp[i]);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    obs_cnt = 0;
    ref_cnt = 0;
    hist    = 4'b0000;
    rstn    = 1'b1;
    in      = 1'b0;

    do_reset("reset_hold", 3);

    drive_seq("single", 5, 32'b10100, 32'b00010);

    do_reset("reset_between", 1);
    drive_seq("overlap", 8, 32'b10101010, 32'b00010101);

    do_reset("reset_between", 1);
    drive_seq("near_miss", 13, 32'b1100100110110, 32'b0000000000000);

    do_reset("reset_between", 1);
    drive_seq("mid_pre", 3, 32'b101, 32'b000);
    do_reset("mid_reset", 1);
    drive_seq("mid_post", 1, 32'b0, 32'b0);
    drive_seq("after_mid", 4, 32'b1010, 32'b0001);

    // Random soak against a 4-bit history reference.
    do_reset("reset_soak", 1);
    obs_cnt = 0;
    ref_cnt = 0;
    for (int i = 0; i < 27; i++) begin
      logic b;
      logic e;
      b    = 1'($urandom_range(1, 0));
      hist = {hist[2:0], b};
      e    = (hist == 4'b1010);
      ref_cnt += int'(e);
      drive_bit("soak_bit", b, e);
    end
    check("soak_count", 32'(obs_cnt), 32'(ref_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/overlap_1010.md
# overlap_1010

Serial bit-stream sequence detector that flags every occurrence of the pattern 1-0-1-0 on a 1-bit input, with overlapping matches allowed. For example, 1010_10 yields two detections. It is a leaf block used wherever a serial data line must be monitored for the 1010 marker. Two FSM styles are supported, selected at compile time:

- **Mealy:** combinational output.
- **Moore:** output decoded from state.

## Interface
- Parameters: none. The FSM style is chosen by the compile-time macro `MEALY_MACHINE`.
  - Defined: Mealy variant.
  - Undefined (default): Moore variant.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rstn` input 1: reset. One clock; reset is synchronous and active-high. The port keeps the codebase name `rstn`, but `rstn`=1 sampled at a rising `clk` edge resets the block.
- `in` input 1: serial data bit, sampled on each rising `clk` edge.
- `out` output 1: detection flag; 1 indicates a completed 1010 match.

## Operation
- Bits are processed MSB-first in time: the pattern is 1, then 0, then 1, then 0 on successive sampled cycles.
- Overlap rule: after a match, the trailing "10" counts as the prefix of the next match.
- Any input sequence is accepted; there is no illegal input. Unused state encodings must return to IDLE on the next edge.

Moore variant: 5 states, registered state, `out` = 1 only in state S1010.
- IDLE: in=1 → S1; in=0 → IDLE.
- S1: in=1 → S1; in=0 → S10.
- S10: in=1 → S101; in=0 → IDLE.
- S101: in=1 → S1; in=0 → S1010.
- S1010 (`out`=1): in=1 → S101; in=0 → IDLE.

Mealy variant: 4 states, `out` = (state==S101) && (in==0), combinational.
- IDLE: in=1 → S1; in=0 → IDLE.
- S1: in=1 → S1; in=0 → S10.
- S10: in=1 → S101; in=0 → IDLE.
- S101: in=1 → S1; in=0 → S10 with `out`=1 during that cycle.

Reset:
- State → IDLE at the rising edge where `rstn`=1.
- `out` = 0 whenever the state is IDLE.
- In Mealy, `out` is additionally gated low while `rstn`=1.

## Timing
- **Moore latency:** `out` rises one clock after the edge that samples the final 0, and stays high for exactly one cycle per match.
- **Mealy latency:** `out` is high during the same cycle the final 0 is present on `in` while in S101 (before the edge), for one cycle per match. It may glitch with `in`, so consumers must sample it on `clk`.
- Reset takes effect on the next rising edge, not immediately. A match in progress is discarded.
- With Moore, an `out`=1 cycle coincident with reset completes, then `out`=0 after the reset edge.
- Reset value of `out`:
  - Moore: 0.
  - Mealy: 0 while reset is held.
- After `rstn` deasserts, the first bit sampled on the following edge is bit 1 of a new search.
- `in` must be stable around the rising `clk` edge. The intended bench drives `in` off-edge.

## Test plan
- **Reset:** hold `rstn`=1 for 3 cycles with `in` toggling → `out`=0 throughout, state IDLE.
- **Single match:** after reset release, drive 1,0,1,0,0 →
  - Moore: `out`=1 in exactly the cycle after the 4th bit's edge.
  - Mealy: `out`=1 while the 4th bit is presented.
  - Otherwise 0.
- **Overlap:** drive 1,0,1,0,1,0,1,0 → 3 detection pulses, at bits 4, 6 and 8.
- **Near-misses:** drive 1,1,0,0,1,0,0,1,1,0,1,1,0 → no pulse.
- **Mid-match reset:** drive 1,0,1, assert `rstn` for 1 cycle, then drive 0 → no pulse. A subsequent 1,0,1,0 detects normally.
- **Random soak:** 27 random bits → `out` pulses exactly match a software reference count of overlapping 1010 matches, with the correct per-variant cycle alignment.
